// File: rtl/timer_ctrl.sv
// MM:SS countdown controller: keypad entry, load/enable of a BCD down-counter chain, alarm.
// Optional pause/resume support is compiled in with `define TIMER_PAUSE_EN.
module timer_ctrl #(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic [3:0]  data_in,
  input  logic        digit_valid,
  input  logic        start,
  input  logic        stop,
  input  logic        clear_key,
  input  logic [3:0]  zeros,
  output logic [15:0] data_out,
  output logic        loadn,
  output logic        cnt_en,
  output logic        alarm,
  output logic [2:0]  state
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        cur;
  logic [PW-1:0] presc;
  logic [AW-1:0] acnt;
  logic          tick_c;
  logic [PW-1:0] presc_nxt_c;
  logic          start_c;

  // Stop outranks start when both strobe together.
  assign start_c     = start && !stop;
  assign tick_c      = (presc == PW'(TICK_DIV - 1));
  assign presc_nxt_c = tick_c ? '0 : presc + PW'(1);
  assign state       = cur;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      cur      <= IDLE;
      data_out <= '0;
      presc    <= '0;
      acnt     <= '0;
      loadn    <= 1'b1;
      cnt_en   <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      loadn  <= 1'b1;
      cnt_en <= 1'b0;
      case (cur)
        IDLE: begin
          presc <= '0;
          if (clear_key) begin
            data_out <= '0;
          end else if (start_c) begin
            if (data_out != '0) begin
              cur   <= LOAD;
              loadn <= 1'b0;
            end
          end else if (!stop && digit_valid && (data_in <= 4'd9)) begin
            data_out <= {data_out[11:0], data_in};
          end
        end
        LOAD: begin
          cur   <= RUN;
          presc <= '0;
        end
        RUN: begin
          if (clear_key) begin
            cur <= IDLE;
          end else if (stop) begin
`ifdef TIMER_PAUSE_EN
            cur <= PAUSE;
`else
            cur <= IDLE;
`endif
          end else if (zeros == 4'hF) begin
            // Expiry wins over a coinciding tick: no enable is issued.
            cur   <= DONE;
            alarm <= 1'b1;
            acnt  <= '0;
            presc <= presc_nxt_c;
          end else begin
            presc  <= presc_nxt_c;
            cnt_en <= tick_c;
          end
        end
        PAUSE: begin
          if (clear_key) begin
            cur <= IDLE;
          end else if (start_c) begin
            cur <= RUN;
          end
        end
        DONE: begin
          if (clear_key || start_c) begin
            cur      <= IDLE;
            alarm    <= 1'b0;
            data_out <= '0;
            acnt     <= '0;
          end else begin
            presc <= presc_nxt_c;
            if (tick_c) begin
              if (acnt == AW'(ALARM_TICKS - 1)) begin
                cur      <= IDLE;
                alarm    <= 1'b0;
                data_out <= '0;
                acnt     <= '0;
              end else begin
                acnt <= acnt + AW'(1);
              end
            end
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus random stimulus vs. a behavioural model.
module tb_timer_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned AT = 3;

  logic        clock;
  logic        clrn;
  logic [3:0]  data_in;
  logic        digit_valid;
  logic        start;
  logic        stop;
  logic        clear_key;
  logic [3:0]  zeros;
  logic [15:0] data_out;
  logic        loadn;
  logic        cnt_en;
  logic        alarm;
  logic [2:0]  state;

  timer_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clock(clock), .clrn(clrn), .data_in(data_in), .digit_valid(digit_valid),
    .start(start), .stop(stop), .clear_key(clear_key), .zeros(zeros),
    .data_out(data_out), .loadn(loadn), .cnt_en(cnt_en), .alarm(alarm), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: mode 0..4 = idle, load, run, pause, done.
  int          m_mode;
  logic [15:0] m_entry;
  int          m_phase;
  int          m_ticks;
  bit          m_loadn, m_cnt, m_alarm;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_entry = '0; m_phase = 0; m_ticks = 0;
    m_loadn = 1'b1; m_cnt = 1'b0; m_alarm = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_edge();
    bit clr, stp, sta, wrap;
    clr = clear_key;
    stp = stop && !clear_key;
    sta = start && !stop && !clear_key;
    m_loadn = 1'b1;
    m_cnt   = 1'b0;
    case (m_mode)
      0: begin
        m_phase = 0;
        if (clr) m_entry = '0;
        else if (sta) begin
          if (m_entry != 0) begin m_mode = 1; m_loadn = 1'b0; end
        end else if (!stp && digit_valid && data_in < 10)
          m_entry = 16'((m_entry * 16) + data_in);
      end
      1: begin m_mode = 2; m_phase = 0; end
      2: begin
        if (clr) m_mode = 0;
        else if (stp) begin
`ifdef TIMER_PAUSE_EN
          m_mode = 3;
`else
          m_mode = 0;
`endif
        end else begin
          wrap = (m_phase == TD - 1);
          m_phase = (m_phase + 1) % TD;
          if (zeros == 4'hF) begin m_mode = 4; m_alarm = 1'b1; m_ticks = 0; end
          else m_cnt = wrap;
        end
      end
      3: begin
        if (clr) m_mode = 0;
        else if (sta) m_mode = 2;
      end
      4: begin
        if (clr || sta) begin
          m_mode = 0; m_alarm = 1'b0; m_entry = '0; m_ticks = 0;
        end else begin
          wrap = (m_phase == TD - 1);
          m_phase = (m_phase + 1) % TD;
          if (wrap) begin
            m_ticks++;
            if (m_ticks == AT) begin
              m_mode = 0; m_alarm = 1'b0; m_entry = '0; m_ticks = 0;
            end
          end
        end
      end
      default: m_mode = 0;
    endcase
  endfunction

  task automatic compare_all();
    check("state",    16'(state),    16'(m_mode));
    check("data_out", data_out,      m_entry);
    check("loadn",    16'(loadn),    16'(m_loadn));
    check("cnt_en",   16'(cnt_en),   16'(m_cnt));
    check("alarm",    16'(alarm),    16'(m_alarm));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    digit_valid = 1'b0; data_in = 4'd0; start = 1'b0; stop = 1'b0;
    clear_key = 1'b0; zeros = 4'd0;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1; data_in = d; step(); digit_valid = 1'b0;
  endtask

  task automatic press_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic press_stop();  stop = 1'b1; step(); stop = 1'b0; endtask
  task automatic press_clear(); clear_key = 1'b1; step(); clear_key = 1'b0; endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #3;
    clrn = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    clrn = 1'b1;
  endtask

  task automatic enter_0130();
    key(4'd0); key(4'd1); key(4'd3); key(4'd0);
  endtask

  initial begin
    int r;
    idle_inputs();
    clrn = 1'b0;
    model_reset();
    #12;
    compare_all();
    check("rst_state", 16'(state), 16'd0);
    check("rst_loadn", 16'(loadn), 16'd1);
    #1;
    clrn = 1'b1;

    // Start with empty entry is ignored.
    press_start();
    check("start_zero_state", 16'(state), 16'd0);
    check("start_zero_loadn", 16'(loadn), 16'd1);

    // Out-of-range key is dropped.
    key(4'd1); key(4'd12); key(4'd5);
    check("key12_dout", data_out, 16'h0015);
    press_clear();
    check("clear_dout", data_out, 16'h0000);

    // Load, single-cycle loadn, one enable every TD cycles.
    enter_0130();
    check("entry_0130", data_out, 16'h0130);
    press_start();
    check("load_state", 16'(state), 16'd1);
    check("load_loadn", 16'(loadn), 16'd0);
    step();
    check("run_state", 16'(state), 16'd2);
    check("run_loadn", 16'(loadn), 16'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("run_tick", 16'(cnt_en), 16'((k % TD) == 0));
    end

    // Expiry sampled together with the prescaler's last count.
    step(); step(); step();
    zeros = 4'hF;
    step();
    zeros = 4'h0;
    check("done_state", 16'(state), 16'd4);
    check("done_cnt",   16'(cnt_en), 16'd0);
    check("done_alarm", 16'(alarm), 16'd1);
    for (int k = 0; k < AT * TD - 1; k++) begin
      step();
      check("alarm_hold", 16'(alarm), 16'd1);
    end
    step();
    check("alarm_end_state", 16'(state), 16'd0);
    check("alarm_end_alarm", 16'(alarm), 16'd0);
    check("alarm_end_dout",  data_out, 16'h0000);

    // Stop at prescaler 2.
    enter_0130();
    press_start();
    step(); step(); step();
    press_stop();
`ifdef TIMER_PAUSE_EN
    check("pause_state", 16'(state), 16'd3);
    for (int k = 0; k < 10; k++) begin
      step();
      check("pause_cnt", 16'(cnt_en), 16'd0);
    end
    press_start();
    check("resume_state", 16'(state), 16'd2);
    step();
    check("resume_cnt1", 16'(cnt_en), 16'd0);
    step();
    check("resume_cnt2", 16'(cnt_en), 16'd1);
`else
    check("stop_state", 16'(state), 16'd0);
    check("stop_dout",  data_out, 16'h0130);
`endif
    press_clear();
    press_clear();

    // Asynchronous reset in the middle of a run.
    key(4'd7);
    press_start();
    step(); step(); step();
    pulse_reset();
    check("arst_state", 16'(state), 16'd0);
    check("arst_dout",  data_out, 16'h0000);
    check("arst_loadn", 16'(loadn), 16'd1);
    check("arst_cnt",   16'(cnt_en), 16'd0);
    check("arst_alarm", 16'(alarm), 16'd0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      digit_valid = (($urandom % 3) == 0);
      data_in     = 4'($urandom);
      r           = int'($urandom % 100);
      clear_key   = (r < 2);
      stop        = (r >= 2 && r < 5) || (r == 99);
      start       = (r >= 5 && r < 14) || (r == 99);
      zeros       = (($urandom % 30) == 0) ? 4'hF : 4'($urandom % 15);
      if (($urandom % 700) == 0) pulse_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl
Controller end of the BCD digit-counter interface: drives load/enable into a 4-digit MM:SS down-counter chain and consumes its zero flags.

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100: clock cycles per count tick, minimum 2.
REQ-002 SHALL have parameter ALARM_TICKS, default 10: count ticks alarm stays asserted before auto-return to IDLE.
REQ-003 SHALL have port clock, input, 1: rising-edge clock.
REQ-004 SHALL have port clrn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port data_in, input, 4: keypad BCD digit.
REQ-006 SHALL have port digit_valid, input, 1: one-cycle strobe qualifying data_in.
REQ-007 SHALL have ports start, stop and clear_key, input, 1 each: one-cycle command strobes.
REQ-008 SHALL have port zeros, input, 4: zero flags from the counters [3]=min tens, [2]=min ones, [1]=sec tens, [0]=sec ones.
REQ-009 SHALL have port data_out, output, 16: preset value {mt,mo,st,so}, equal to the entry register.
REQ-010 SHALL have port loadn, output, 1: active-low parallel load to the counters.
REQ-011 SHALL have port cnt_en, output, 1: one-cycle count-enable pulse to the seconds-ones counter.
REQ-012 SHALL have port alarm, output, 1: expiry indication.
REQ-013 SHALL have port state, output, 3: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

Function
REQ-014 SHALL act on commands with priority clear_key > stop > start, at most one per cycle.
REQ-015 SHALL, in IDLE on digit_valid with data_in<=9, shift the entry register left 4 bits and insert data_in at [3:0]; data_in>9 SHALL be ignored.
REQ-016 SHALL ignore digit_valid in every state other than IDLE.
REQ-017 SHALL, in IDLE on clear_key, clear the entry register to 16'h0000.
REQ-018 SHALL, in IDLE on start with entry nonzero, go to LOAD; start with entry zero SHALL be ignored.
REQ-019 SHALL hold loadn=0 for exactly the single LOAD cycle, then go to RUN with the prescaler cleared to 0; loadn=1 in all other states.
REQ-020 SHALL, in RUN, increment the prescaler each cycle and pulse cnt_en for one cycle when the prescaler equals TICK_DIV-1, wrapping it to 0.
REQ-021 SHALL, in RUN, go to DONE in the cycle zeros==4'hF is sampled, with no cnt_en that cycle; this check SHALL take precedence over the tick.
REQ-022 SHALL, in RUN or PAUSE on clear_key, go to IDLE keeping the entry register.
REQ-023 SHALL, in DONE, assert alarm, continue the prescaler, and count ALARM_TICKS ticks without asserting cnt_en.
REQ-024 SHALL leave DONE for IDLE after ALARM_TICKS ticks, or earlier on clear_key or start, clearing alarm and the entry register.
REQ-025 SHALL drive cnt_en=0 in IDLE, LOAD, PAUSE and DONE.

Reset
REQ-026 SHALL, on clrn=0 at any time including mid-RUN, immediately set state=IDLE, entry=0, prescaler=0, alarm count=0, loadn=1, cnt_en=0, alarm=0.

Configuration
REQ-027 SHALL, with TIMER_PAUSE_EN defined, on stop in RUN go to PAUSE with the prescaler frozen, and on start in PAUSE return to RUN resuming the prescaler value.
REQ-028 SHALL, without TIMER_PAUSE_EN, on stop in RUN go to IDLE keeping the entry register; PAUSE SHALL be unreachable.

Verification
REQ-029 SHALL cover this case: TICK_DIV=4; keys 0,1,3,0 then start -> data_out=16'h0130, loadn low one cycle, cnt_en every 4th cycle in RUN.
REQ-030 SHALL cover this case: keys 1, 12, 5 -> data_out=16'h0015, key 12 ignored.
REQ-031 SHALL cover this case: in RUN, zeros forced to 4'hF on the same cycle the prescaler is 3 -> state=DONE next cycle, no cnt_en, alarm=1 for ALARM_TICKS x TICK_DIV cycles, then IDLE with entry 0.
REQ-032 SHALL cover this case: TIMER_PAUSE_EN defined, stop at prescaler=2, wait 10 cycles, start -> no cnt_en while paused, first cnt_en 2 cycles after resume; without the macro, same stop -> IDLE, data_out unchanged.
REQ-033 SHALL cover this case: start with entry 0 -> state stays IDLE, loadn stays 1.
REQ-034 SHALL cover this case: clrn pulsed low mid-RUN -> all outputs at reset values asynchronously, state=0.
